led_frame_buffer: RTL and testbench

LED_FRAME_BUFFER -- requirements
Module: led_frame_buffer

---
 rtl/led_pkg.sv | 32 +++
 rtl/led_frame_buffer.sv | 188 ++++++++++++++++++
 tb/tb_led_frame_buffer.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED frame buffer: bus-transaction states and
// helpers that derive the buffer geometry from the LED chain parameters.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PTR = 2'd1,
    XFER     = 2'd2
  } state_t;

  function automatic int calc_bytes(input int led_cnt, input int channels);
    return led_cnt * channels;
  endfunction

  function automatic int calc_frame_w(input int bytes);
    return bytes * 8;
  endfunction

  function automatic int calc_ptr_w(input int bytes);
    return $clog2(bytes);
  endfunction

  // The serializer shifts bit 8n first, so byte MSBs land on the low index.
  function automatic logic [7:0] bit_reverse8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/led_frame_buffer.sv
// I2C-fed double-buffered LED frame store. Bytes written over the bus land in
// a shadow buffer; a STOP after any write copies the whole shadow into the
// active buffer that drives the serializer, deferred while it is busy.
module led_frame_buffer
  import led_pkg::*;
#(
  parameter int LED_CNT  = 3,
  parameter int CHANNELS = 3,
  parameter int WRAP     = 1,
  localparam int BYTES   = calc_bytes(LED_CNT, CHANNELS),
  localparam int FRAME_W = calc_frame_w(BYTES),
  localparam int PTR_W   = calc_ptr_w(BYTES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               ptr_valid,
  input  logic [7:0]         ptr,
  input  logic               wr_valid,
  input  logic [7:0]         wr_data,
  input  logic               rd_req,
  output logic [7:0]         rd_data,
  input  logic               tx_busy,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_update,
  output logic               commit_pending,
  output logic               err
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BYTES - 1);
  localparam logic [7:0]       BYTES_B  = 8'(BYTES);
  localparam bit               WRAP_EN  = (WRAP != 0);

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] ptr_reg, ptr_next, ptr_adv;
  logic             sat_reg, sat_next, sat_adv;
  logic             dirty_reg, dirty_next;
  logic             pend_reg, pend_next;
  logic             err_reg, err_next;
  logic             update_reg, update_next;
  logic [7:0]       rd_data_reg, rd_data_next;
  logic             shadow_we;
  logic             copy_en;
  logic             stop_commit;

  logic [7:0] shadow_reg [BYTES];
  logic [7:0] active_reg [BYTES];

  // Pointer advance after a byte is consumed: wrap to 0, or park on the last
  // byte and mark the buffer exhausted.
  always_comb begin
    ptr_adv = ptr_reg + 1'b1;
    sat_adv = 1'b0;
    if (ptr_reg == LAST_PTR) begin
      ptr_adv = WRAP_EN ? '0 : ptr_reg;
      sat_adv = !WRAP_EN;
    end
  end

  // Transaction sequencing plus commit scheduling.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    sat_next     = sat_reg;
    dirty_next   = dirty_reg;
    pend_next    = pend_reg;
    err_next     = err_reg;
    update_next  = 1'b0;
    rd_data_next = rd_data_reg;
    shadow_we    = 1'b0;
    copy_en      = 1'b0;

    // Copy uses this cycle's shadow; a write on the same edge re-dirties below.
    stop_commit = stop && !start && dirty_reg;
    if ((stop_commit || pend_reg) && !tx_busy) begin
      copy_en     = 1'b1;
      update_next = 1'b1;
      pend_next   = 1'b0;
      dirty_next  = 1'b0;
    end else if (stop_commit) begin
      pend_next = 1'b1;
    end

    if (start) begin
      state_next = WAIT_PTR;
      err_next   = 1'b0;
      // A repeated START keeps dirty so the write half still commits at STOP.
      if (state_reg == IDLE) begin
        dirty_next = 1'b0;
      end
    end else if (stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        WAIT_PTR: begin
          if (ptr_valid) begin
            state_next = XFER;
            sat_next   = 1'b0;
            if (ptr < BYTES_B) begin
              ptr_next = ptr[PTR_W-1:0];
            end else begin
              ptr_next = '0;
              err_next = 1'b1;
            end
          end
        end
        XFER: begin
          if (wr_valid) begin
            if (sat_reg) begin
              err_next = 1'b1;
            end else begin
              shadow_we  = 1'b1;
              dirty_next = 1'b1;
              ptr_next   = ptr_adv;
              sat_next   = sat_adv;
            end
          end else if (rd_req) begin
            if (sat_reg) begin
              rd_data_next = 8'h00;
              err_next     = 1'b1;
            end else begin
              rd_data_next = shadow_reg[ptr_reg];
              ptr_next     = ptr_adv;
              sat_next     = sat_adv;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      sat_reg     <= 1'b0;
      dirty_reg   <= 1'b0;
      pend_reg    <= 1'b0;
      err_reg     <= 1'b0;
      update_reg  <= 1'b0;
      rd_data_reg <= 8'h00;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      sat_reg     <= sat_next;
      dirty_reg   <= dirty_next;
      pend_reg    <= pend_next;
      err_reg     <= err_next;
      update_reg  <= update_next;
      rd_data_reg <= rd_data_next;
    end
  end

  // Shadow and active byte stores; active only moves on a commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BYTES; i++) begin
        shadow_reg[i] <= 8'h00;
        active_reg[i] <= 8'h00;
      end
    end else begin
      if (shadow_we) begin
        shadow_reg[ptr_reg] <= wr_data;
      end
      if (copy_en) begin
        for (int i = 0; i < BYTES; i++) begin
          active_reg[i] <= shadow_reg[i];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_frame
      assign frame[8*gi +: 8] = bit_reverse8(active_reg[gi]);
    end
  endgenerate

  assign rd_data        = rd_data_reg;
  assign frame_update   = update_reg;
  assign commit_pending = pend_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Bench for led_frame_buffer: a wrapping and a saturating instance share the
// same stimulus; hand tables, directed corner sequences and random traffic
// are checked against a byte-level reference model of the buffer.
module tb_led_frame_buffer;

  localparam int NB = 9;

  logic        clk = 1'b0;
  logic        reset, start, stop, ptr_valid, wr_valid, rd_req, tx_busy;
  logic [7:0]  ptr, wr_data;
  logic [7:0]  rd_data_w, rd_data_s;
  logic [71:0] frame_w, frame_s;
  logic        upd_w, upd_s, pend_w, pend_s, err_w, err_s;

  always #5 clk = ~clk;

  led_frame_buffer #(.LED_CNT(3), .CHANNELS(3), .WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .ptr_valid(ptr_valid), .ptr(ptr), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_req(rd_req), .rd_data(rd_data_w), .tx_busy(tx_busy), .frame(frame_w),
    .frame_update(upd_w), .commit_pending(pend_w), .err(err_w)
  );

  led_frame_buffer #(.LED_CNT(3), .CHANNELS(3), .WRAP(0)) dut_s (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .ptr_valid(ptr_valid), .ptr(ptr), .wr_valid(wr_valid), .wr_data(wr_data),
    .rd_req(rd_req), .rd_data(rd_data_s), .tx_busy(tx_busy), .frame(frame_s),
    .frame_update(upd_s), .commit_pending(pend_s), .err(err_s)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %0b expected %0b", name, $time, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  task automatic chkf(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got %018h expected %018h", name, $time, act, exp);
    end
  endtask

  // Expected frame image: byte v placed bit-reversed into slot n.
  function automatic logic [71:0] place(input logic [71:0] base, input int n, input logic [7:0] v);
    logic [71:0] f;
    f = base;
    for (int k = 0; k < 8; k++) f[8*n+k] = v[7-k];
    return f;
  endfunction

  // ---------------- reference model (index 0 = wrapping, 1 = saturating)
  logic [7:0] m_sh [2][NB];
  logic [7:0] m_ac [2][NB];
  logic [7:0] m_rd [2];
  int         m_mode [2];   // 0 idle, 1 waiting for pointer, 2 transferring
  int         m_ptr [2];
  bit         m_done [2], m_dirty [2], m_pend [2], m_err [2], m_upd [2];

  function automatic logic [71:0] model_frame(input int w);
    logic [71:0] f;
    f = '0;
    for (int n = 0; n < NB; n++) f = place(f, n, m_ac[w][n]);
    return f;
  endfunction

  task automatic model_next_byte(input int w);
    if (m_ptr[w] == NB - 1) begin
      if (w == 0) m_ptr[w] = 0;
      else m_done[w] = 1'b1;
    end else begin
      m_ptr[w] = m_ptr[w] + 1;
    end
  endtask

  task automatic model_step(input int w);
    bit commit_req;
    m_upd[w] = 1'b0;
    if (reset) begin
      for (int n = 0; n < NB; n++) begin
        m_sh[w][n] = 8'h00;
        m_ac[w][n] = 8'h00;
      end
      m_rd[w] = 8'h00; m_mode[w] = 0; m_ptr[w] = 0; m_done[w] = 0;
      m_dirty[w] = 0; m_pend[w] = 0; m_err[w] = 0;
    end else begin
      commit_req = stop && !start && m_dirty[w];
      if ((commit_req || m_pend[w]) && !tx_busy) begin
        for (int n = 0; n < NB; n++) m_ac[w][n] = m_sh[w][n];
        m_upd[w] = 1'b1; m_pend[w] = 1'b0; m_dirty[w] = 1'b0;
      end else if (commit_req) begin
        m_pend[w] = 1'b1;
      end
      if (start) begin
        if (m_mode[w] == 0) m_dirty[w] = 1'b0;
        m_err[w] = 1'b0;
        m_mode[w] = 1;
      end else if (stop) begin
        m_mode[w] = 0;
      end else if (m_mode[w] == 1 && ptr_valid) begin
        m_mode[w] = 2;
        m_done[w] = 1'b0;
        if (int'(ptr) < NB) m_ptr[w] = int'(ptr);
        else begin m_ptr[w] = 0; m_err[w] = 1'b1; end
      end else if (m_mode[w] == 2 && wr_valid) begin
        if (m_done[w]) m_err[w] = 1'b1;
        else begin
          m_sh[w][m_ptr[w]] = wr_data;
          m_dirty[w] = 1'b1;
          model_next_byte(w);
        end
      end else if (m_mode[w] == 2 && rd_req) begin
        if (m_done[w]) begin m_rd[w] = 8'h00; m_err[w] = 1'b1; end
        else begin
          m_rd[w] = m_sh[w][m_ptr[w]];
          model_next_byte(w);
        end
      end
    end
  endtask

  // One clock: advance the model on the edge, compare both DUTs just after.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    chk8("model.w.rd_data", rd_data_w, m_rd[0]);
    chk1("model.w.err", err_w, m_err[0]);
    chk1("model.w.frame_update", upd_w, m_upd[0]);
    chk1("model.w.commit_pending", pend_w, m_pend[0]);
    chkf("model.w.frame", frame_w, model_frame(0));
    chk8("model.s.rd_data", rd_data_s, m_rd[1]);
    chk1("model.s.err", err_s, m_err[1]);
    chk1("model.s.frame_update", upd_s, m_upd[1]);
    chk1("model.s.commit_pending", pend_s, m_pend[1]);
    chkf("model.s.frame", frame_s, model_frame(1));
  endtask

  task automatic cyc(input logic st, input logic sp, input logic pv, input logic [7:0] p,
                     input logic wv, input logic [7:0] wd, input logic rr);
    start = st; stop = sp; ptr_valid = pv; ptr = p; wr_valid = wv; wr_data = wd; rd_req = rr;
    tick();
    start = 0; stop = 0; ptr_valid = 0; wr_valid = 0; rd_req = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    logic st, sp, pv;
    logic [7:0] p;
    logic wv;
    logic [7:0] wd;
    logic rr;
    logic [7:0] e_rd;
    logic e_err, e_upd;
    logic [71:0] e_frame;
  } vec_t;

  vec_t tbl [20];

  initial begin
    logic [71:0] f1, f2, fw, fs;
    reset = 1'b1; start = 0; stop = 0; ptr_valid = 0; ptr = 0;
    wr_valid = 0; wr_data = 0; rd_req = 0; tx_busy = 0;
    do_reset();
    chkf("reset.frame_w", frame_w, 72'h0);
    chkf("reset.frame_s", frame_s, 72'h0);
    chk1("reset.err_w", err_w, 1'b0);
    chk8("reset.rd_data_w", rd_data_w, 8'h00);

    // Single-byte commit, then a write, repeated START and reads.
    f1 = place(72'h0, 0, 8'h80);
    f2 = place(place(f1, 3, 8'h5A), 4, 8'hC3);
    tbl[0]  = '{1,0,0,8'd0,0,8'h00,0, 8'h00,0,0,72'h0};
    tbl[1]  = '{0,0,1,8'd0,0,8'h00,0, 8'h00,0,0,72'h0};
    tbl[2]  = '{0,0,0,8'd0,1,8'h80,0, 8'h00,0,0,72'h0};
    tbl[3]  = '{0,1,0,8'd0,0,8'h00,0, 8'h00,0,1,f1};
    tbl[4]  = '{0,0,0,8'd0,0,8'h00,0, 8'h00,0,0,f1};
    tbl[5]  = '{1,0,0,8'd0,0,8'h00,0, 8'h00,0,0,f1};
    tbl[6]  = '{0,0,1,8'd3,0,8'h00,0, 8'h00,0,0,f1};
    tbl[7]  = '{0,0,0,8'd0,1,8'h5A,0, 8'h00,0,0,f1};
    tbl[8]  = '{0,0,0,8'd0,1,8'hC3,0, 8'h00,0,0,f1};
    tbl[9]  = '{1,0,0,8'd0,0,8'h00,0, 8'h00,0,0,f1};
    tbl[10] = '{0,0,1,8'd3,0,8'h00,0, 8'h00,0,0,f1};
    tbl[11] = '{0,0,0,8'd0,0,8'h00,1, 8'h5A,0,0,f1};
    tbl[12] = '{0,0,0,8'd0,0,8'h00,1, 8'hC3,0,0,f1};
    tbl[13] = '{0,1,0,8'd0,0,8'h00,0, 8'hC3,0,1,f2};
    tbl[14] = '{1,0,0,8'd0,0,8'h00,0, 8'hC3,0,0,f2};
    tbl[15] = '{0,0,1,8'd3,0,8'h00,0, 8'hC3,0,0,f2};
    tbl[16] = '{0,0,0,8'd0,0,8'h00,1, 8'h5A,0,0,f2};
    tbl[17] = '{0,0,0,8'd0,0,8'h00,1, 8'hC3,0,0,f2};
    tbl[18] = '{0,1,0,8'd0,0,8'h00,0, 8'hC3,0,0,f2};
    tbl[19] = '{0,0,0,8'd0,0,8'h00,0, 8'hC3,0,0,f2};
    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].st, tbl[i].sp, tbl[i].pv, tbl[i].p, tbl[i].wv, tbl[i].wd, tbl[i].rr);
      chk8($sformatf("tbl%0d.rd_w", i), rd_data_w, tbl[i].e_rd);
      chk8($sformatf("tbl%0d.rd_s", i), rd_data_s, tbl[i].e_rd);
      chk1($sformatf("tbl%0d.err_w", i), err_w, tbl[i].e_err);
      chk1($sformatf("tbl%0d.upd_w", i), upd_w, tbl[i].e_upd);
      chk1($sformatf("tbl%0d.upd_s", i), upd_s, tbl[i].e_upd);
      chkf($sformatf("tbl%0d.frame_w", i), frame_w, tbl[i].e_frame);
      chkf($sformatf("tbl%0d.frame_s", i), frame_s, tbl[i].e_frame);
    end

    // Writes crossing the end of the buffer from pointer 7.
    do_reset();
    cyc(1,0,0,0,0,0,0);
    cyc(0,0,1,8'd7,0,0,0);
    cyc(0,0,0,0,1,8'hAA,0);
    cyc(0,0,0,0,1,8'hBB,0);
    cyc(0,0,0,0,1,8'hCC,0);
    chk1("wrap.err_w", err_w, 1'b0);
    chk1("sat.err_s", err_s, 1'b1);
    cyc(0,1,0,0,0,0,0);
    fw = place(place(place(72'h0, 7, 8'hAA), 8, 8'hBB), 0, 8'hCC);
    fs = place(place(72'h0, 7, 8'hAA), 8, 8'hBB);
    chkf("wrap.frame_w", frame_w, fw);
    chkf("sat.frame_s", frame_s, fs);
    chk1("wrap.upd_w", upd_w, 1'b1);

    // Saturating pointer at the last byte; err sticks until the next START.
    cyc(1,0,0,0,0,0,0);
    chk1("sat.err_cleared_s", err_s, 1'b0);
    cyc(0,0,1,8'd8,0,0,0);
    cyc(0,0,0,0,1,8'h11,0);
    chk1("sat.err_after_last_s", err_s, 1'b0);
    cyc(0,0,0,0,1,8'h22,0);
    chk1("sat.err_drop_s", err_s, 1'b1);
    chk1("sat.err_w", err_w, 1'b0);
    cyc(0,1,0,0,0,0,0);
    chkf("sat.frame_s2", frame_s, place(fs, 8, 8'h11));
    chkf("sat.frame_w2", frame_w, place(place(fw, 8, 8'h11), 0, 8'h22));
    cyc(0,0,0,0,0,0,0);
    chk1("sat.err_sticky_s", err_s, 1'b1);
    cyc(1,0,0,0,0,0,0);
    chk1("sat.err_start_s", err_s, 1'b0);
    cyc(0,1,0,0,0,0,0);

    // Commit deferred while the serializer is busy.
    do_reset();
    cyc(1,0,0,0,0,0,0);
    cyc(0,0,1,8'd0,0,0,0);
    cyc(0,0,0,0,1,8'h05,0);
    tx_busy = 1'b1;
    cyc(0,1,0,0,0,0,0);
    for (int i = 0; i < 19; i++) begin
      chk1($sformatf("busy%0d.pend", i), pend_w, 1'b1);
      chk1($sformatf("busy%0d.upd", i), upd_w, 1'b0);
      chkf($sformatf("busy%0d.frame", i), frame_w, 72'h0);
      tick();
    end
    chk1("busy.pend_last", pend_w, 1'b1);
    tx_busy = 1'b0;
    tick();
    chk1("busy.upd_after_fall", upd_w, 1'b1);
    chk1("busy.pend_after_fall", pend_w, 1'b0);
    chkf("busy.frame_after_fall", frame_w, place(72'h0, 0, 8'h05));
    tick();
    chk1("busy.upd_single", upd_w, 1'b0);

    // Out-of-range pointer, then reset in the middle of a write.
    do_reset();
    cyc(1,0,0,0,0,0,0);
    cyc(0,0,1,8'd9,0,0,0);
    chk1("badptr.err_w", err_w, 1'b1);
    chk1("badptr.err_s", err_s, 1'b1);
    cyc(0,0,0,0,1,8'h77,0);
    cyc(0,0,0,0,1,8'h66,0);
    cyc(1,0,0,0,0,0,0);
    cyc(0,0,1,8'd0,0,0,0);
    cyc(0,0,0,0,0,0,1);
    chk8("badptr.rd_w", rd_data_w, 8'h77);
    reset = 1'b1;
    cyc(0,0,0,0,1,8'h99,0);
    reset = 1'b0;
    chkf("rst.frame_w", frame_w, 72'h0);
    chk1("rst.err_w", err_w, 1'b0);
    chk8("rst.rd_w", rd_data_w, 8'h00);
    cyc(0,1,0,0,0,0,0);
    chk1("rst.no_update", upd_w, 1'b0);
    chkf("rst.frame_after_stop", frame_w, 72'h0);

    // Random bus traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int r;
      reset     = ($urandom_range(0, 599) == 0);
      start     = ($urandom_range(0, 99) < 3);
      stop      = ($urandom_range(0, 99) < 4);
      ptr_valid = ($urandom_range(0, 99) < 12);
      ptr       = 8'($urandom_range(0, 11));
      r         = $urandom_range(0, 99);
      wr_valid  = (r < 30);
      rd_req    = (r >= 30 && r < 45);
      wr_data   = 8'($urandom);
      if ($urandom_range(0, 99) < 6) tx_busy = ~tx_busy;
      tick();
    end
    reset = 0; start = 0; stop = 0; ptr_valid = 0; wr_valid = 0; rd_req = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
